// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: emulates the RTC chip on the multiplexed CS/AD/RD/WR bus.
// Holds the BCD calendar, a one-shot BCD countdown timer and the active-low timer irq.
module rtc_bus_responder #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS,
  input  logic       AD,
  input  logic       RD,
  input  logic       WR,
  inout  wire  [7:0] datRTC,
  output logic       irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ADDR_WR, DATA_WR, DATA_RD} state_t;

  logic [3:0] raw;
  logic [3:0] sync_s;
  logic       cs_s, ad_s, rd_s, wr_s;

  assign raw = {CS, AD, RD, WR};

  // Synchronizers reset to the idle (deasserted) bus level so no edge is seen at reset release.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) chain_reg <= '1;
        else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
      end
      assign sync_s[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign cs_s = sync_s[3];
  assign ad_s = sync_s[2];
  assign rd_s = sync_s[1];
  assign wr_s = sync_s[0];

  state_t      state_reg;
  logic [1:0]  prev_reg;
  logic [7:0]  addr_reg, rd_data_reg;
  logic        drive_reg;
  logic [7:0]  sec_reg, min_reg, hr_reg, day_reg, mon_reg, yr_reg;
  logic [7:0]  tsec_reg, tmin_reg, thr_reg;
  logic [2:0]  ctrl_reg;
  logic [PW-1:0] presc_reg;
  logic        pending_reg, irq_reg;

  logic rd_fall, rd_rise, wr_fall, wr_rise, data_write;
  logic [7:0] rd_mux;

  assign rd_fall    = prev_reg[1] & ~rd_s;
  assign rd_rise    = ~prev_reg[1] & rd_s;
  assign wr_fall    = prev_reg[0] & ~wr_s;
  assign wr_rise    = ~prev_reg[0] & wr_s;
  assign data_write = (state_reg == DATA_WR) && !cs_s && rd_s && wr_rise;

  assign datRTC = drive_reg ? rd_data_reg : 8'hzz;
  assign irq    = irq_reg;

  always_comb begin
    rd_mux = 8'h00;
    case (addr_reg)
      8'h00:   rd_mux = {5'd0, ctrl_reg};
      8'h21:   rd_mux = sec_reg;
      8'h22:   rd_mux = min_reg;
      8'h23:   rd_mux = hr_reg;
      8'h24:   rd_mux = day_reg;
      8'h25:   rd_mux = mon_reg;
      8'h26:   rd_mux = yr_reg;
      8'h41:   rd_mux = tsec_reg;
      8'h42:   rd_mux = tmin_reg;
      8'h43:   rd_mux = thr_reg;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      prev_reg    <= 2'b11;
      addr_reg    <= 8'h00;
      rd_data_reg <= 8'h00;
      drive_reg   <= 1'b0;
    end else begin
      prev_reg <= {rd_s, wr_s};
      case (state_reg)
        IDLE: begin
          drive_reg <= 1'b0;
          if (!cs_s && wr_fall && rd_s) begin
            state_reg <= ad_s ? DATA_WR : ADDR_WR;
          end else if (!cs_s && rd_fall && wr_s && ad_s) begin
            state_reg   <= DATA_RD;
            rd_data_reg <= rd_mux;
            drive_reg   <= 1'b1;
          end
        end
        ADDR_WR: begin
          if (cs_s || !rd_s) state_reg <= IDLE;
          else if (wr_rise) begin
            addr_reg  <= datRTC;
            state_reg <= IDLE;
          end
        end
        DATA_WR: begin
          // The register write itself is performed by the timekeeping block via data_write.
          if (cs_s || !rd_s || wr_rise) state_reg <= IDLE;
        end
        DATA_RD: begin
          if (cs_s || rd_rise || !wr_s) begin
            state_reg <= IDLE;
            drive_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          drive_reg <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_inc = (v[3:0] >= 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    bcd_dec = (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction

  logic leap, sec_wrap, min_wrap, hr_wrap, day_wrap, mon_wrap, c_day, c_mon;
  logic [7:0] month_len, sec_n, min_n, hr_n, day_n, mon_n, yr_n;
  logic t_zero, t_done;
  logic [7:0] tsec_n, tmin_n, thr_n;

  always_comb begin
    // (10*tens + units) mod 4 == (2*tens + units) mod 4
    leap = ((yr_reg[1:0] + {yr_reg[4], 1'b0}) == 2'b00);
    case (mon_reg)
      8'h02:                      month_len = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
    sec_wrap = (sec_reg >= 8'h59);
    min_wrap = (min_reg >= 8'h59);
    hr_wrap  = (hr_reg  >= 8'h23);
    day_wrap = (day_reg >= month_len);
    mon_wrap = (mon_reg >= 8'h12);
    c_day    = sec_wrap & min_wrap & hr_wrap;
    c_mon    = c_day & day_wrap;
    sec_n = sec_wrap ? 8'h00 : bcd_inc(sec_reg);
    min_n = sec_wrap ? (min_wrap ? 8'h00 : bcd_inc(min_reg)) : min_reg;
    hr_n  = (sec_wrap & min_wrap) ? (hr_wrap ? 8'h00 : bcd_inc(hr_reg)) : hr_reg;
    day_n = c_day ? (day_wrap ? 8'h01 : bcd_inc(day_reg)) : day_reg;
    mon_n = c_mon ? (mon_wrap ? 8'h01 : bcd_inc(mon_reg)) : mon_reg;
    yr_n  = (c_mon & mon_wrap) ? ((yr_reg >= 8'h99) ? 8'h00 : bcd_inc(yr_reg)) : yr_reg;

    t_zero = ({thr_reg, tmin_reg, tsec_reg} == 24'd0);
    tsec_n = (tsec_reg == 8'h00) ? 8'h59 : bcd_dec(tsec_reg);
    tmin_n = (tsec_reg == 8'h00) ? ((tmin_reg == 8'h00) ? 8'h59 : bcd_dec(tmin_reg)) : tmin_reg;
    thr_n  = (tsec_reg == 8'h00 && tmin_reg == 8'h00) ? bcd_dec(thr_reg) : thr_reg;
    t_done = t_zero | ({thr_n, tmin_n, tsec_n} == 24'd0);
  end

  logic tick_now, tick_go;
  assign tick_now = (presc_reg == PW'(TICK_DIV - 1));
  // A tick colliding with a bus write is deferred by one clk so the write always lands.
  assign tick_go  = (tick_now | pending_reg) & ~data_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_reg     <= 8'h00;
      min_reg     <= 8'h00;
      hr_reg      <= 8'h00;
      day_reg     <= 8'h01;
      mon_reg     <= 8'h01;
      yr_reg      <= 8'h00;
      tsec_reg    <= 8'h00;
      tmin_reg    <= 8'h00;
      thr_reg     <= 8'h00;
      ctrl_reg    <= 3'b000;
      presc_reg   <= '0;
      pending_reg <= 1'b0;
      irq_reg     <= 1'b1;
    end else begin
      if ((data_write && addr_reg == 8'h21) || tick_now) presc_reg <= '0;
      else                                               presc_reg <= presc_reg + 1'b1;
      pending_reg <= (tick_now | pending_reg) & data_write;
      irq_reg     <= ~(ctrl_reg[2] & ctrl_reg[1]);

      if (tick_go) begin
        sec_reg <= sec_n;
        min_reg <= min_n;
        hr_reg  <= hr_n;
        day_reg <= day_n;
        mon_reg <= mon_n;
        yr_reg  <= yr_n;
        if (ctrl_reg[0]) begin
          if (!t_zero) begin
            tsec_reg <= tsec_n;
            tmin_reg <= tmin_n;
            thr_reg  <= thr_n;
          end
          if (t_done) begin
            ctrl_reg[2] <= 1'b1;
            ctrl_reg[0] <= 1'b0;
          end
        end
      end

      if (data_write) begin
        case (addr_reg)
          8'h00:   ctrl_reg <= {ctrl_reg[2] & datRTC[2], datRTC[1:0]};
          8'h21:   sec_reg  <= datRTC;
          8'h22:   min_reg  <= datRTC;
          8'h23:   hr_reg   <= datRTC;
          8'h24:   day_reg  <= datRTC;
          8'h25:   mon_reg  <= datRTC;
          8'h26:   yr_reg   <= datRTC;
          8'h41:   tsec_reg <= datRTC;
          8'h42:   tmin_reg <= datRTC;
          8'h43:   thr_reg  <= datRTC;
          default: ;
        endcase
      end
    end
  end

endmodule
